// File: rtl/cfg_loader_pkg.sv
// Shared constants and FSM state type for the configuration-chain loader.
package cfg_loader_pkg;

   localparam int CFG_WIDTH_DEF = 128;   // 5+5+5+9+96+4+4
   localparam int BYTE_W        = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BYTE = 2'd1,
      SHIFT     = 2'd2,
      FINISH    = 2'd3
   } state_e;

endpackage

// File: rtl/cfg_loader_bit_serdes.sv
// Byte serialiser/deserialiser for the configuration chain: LSB-first TX
// shifter, MSB-side RX capture and a bit counter that flags the eighth shift.
module cfg_bit_serdes
   import cfg_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [BYTE_W-1:0] din,
   input  logic              cfg_q,
   output logic              tx_bit_next,
   output logic [BYTE_W-1:0] rx_byte,
   output logic              byte_done
);

   logic [BYTE_W-1:0] tx_q, tx_d;
   logic [BYTE_W-1:0] rx_q, rx_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;

   always_comb begin
      tx_d      = tx_q;
      rx_d      = rx_q;
      bit_cnt_d = bit_cnt_q;
      if (load) begin
         tx_d      = din;
         rx_d      = '0;
         bit_cnt_d = '0;
      end else if (shift) begin
         tx_d      = {1'b0, tx_q[BYTE_W-1:1]};
         rx_d      = {cfg_q, rx_q[BYTE_W-1:1]};
         bit_cnt_d = bit_cnt_q + 3'd1;
      end
   end

   // The registered CFG_D in the top must already hold the bit the shifter
   // will present next cycle, so expose the post-update LSB.
   assign tx_bit_next = tx_d[0];
   assign rx_byte     = rx_d;
   assign byte_done   = shift && (bit_cnt_q == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q      <= '0;
         rx_q      <= '0;
         bit_cnt_q <= '0;
      end else begin
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/cfg_loader.sv
// Byte-parallel front end for the serial configuration chain: loads bytes
// LSB-first onto the chain while reading back the previous contents.
//
//   state     | meaning
//   IDLE      | no load in progress, waiting for START
//   WAIT_BYTE | DIN_READY high, waiting for the next byte
//   SHIFT     | 8 cycles driving CFG_WE/CFG_D, capturing CFG_Q
//   FINISH    | DONE pulse, back to IDLE
module cfg_loader
   import cfg_loader_pkg::*;
#(
   parameter int CFG_WIDTH = CFG_WIDTH_DEF
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ABORT,
   input  logic [7:0] DIN,
   input  logic       DIN_VALID,
   output logic       DIN_READY,
   output logic       CFG_WE,
   output logic       CFG_D,
   input  logic       CFG_Q,
   output logic [7:0] RDATA,
   output logic       RVALID,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   localparam int NBYTES = CFG_WIDTH / BYTE_W;
   localparam int CNT_W  = $clog2(NBYTES + 1);

   if ((CFG_WIDTH % BYTE_W) != 0 || CFG_WIDTH <= 0) begin : g_width_check
      $error("cfg_loader: CFG_WIDTH must be a positive multiple of 8");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic               err_q, err_d;
   logic [BYTE_W-1:0]  rdata_q, rdata_d;
   logic               rvalid_q, rvalid_d;
   logic               cfg_we_q, cfg_we_d;
   logic               cfg_d_q, cfg_d_d;

   logic               load, shift, byte_done, tx_bit_next, last_byte;
   logic [BYTE_W-1:0]  rx_byte;

   assign load      = (state_q == WAIT_BYTE) && DIN_VALID && !ABORT;
   assign shift     = (state_q == SHIFT);
   assign last_byte = (byte_cnt_q == CNT_W'(NBYTES - 1));

   cfg_bit_serdes u_serdes (
      .clk         (CLK),
      .rst         (RST),
      .load        (load),
      .shift       (shift),
      .din         (DIN),
      .cfg_q       (CFG_Q),
      .tx_bit_next (tx_bit_next),
      .rx_byte     (rx_byte),
      .byte_done   (byte_done)
   );

   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (START) state_d = WAIT_BYTE;
         WAIT_BYTE: begin
            if (ABORT)          state_d = IDLE;
            else if (DIN_VALID) state_d = SHIFT;
         end
         SHIFT: begin
            if (ABORT)          state_d = IDLE;
            else if (byte_done) state_d = last_byte ? FINISH : WAIT_BYTE;
         end
         FINISH:    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      if (state_q == IDLE && START) begin
         byte_cnt_d = '0;
         err_d      = 1'b0;
      end
      if ((state_q == WAIT_BYTE || state_q == SHIFT) && ABORT) err_d = 1'b1;
      // An abort on the eighth shift still discards the byte.
      if (byte_done && !ABORT) begin
         rdata_d    = rx_byte;
         rvalid_d   = 1'b1;
         byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
      cfg_we_d  = (state_d == SHIFT);
      cfg_d_d   = cfg_we_d & tx_bit_next;
      BUSY      = (state_q != IDLE);
      DONE      = (state_q == FINISH);
      DIN_READY = (state_q == WAIT_BYTE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         byte_cnt_q <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         cfg_we_q   <= 1'b0;
         cfg_d_q    <= 1'b0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         cfg_we_q   <= cfg_we_d;
         cfg_d_q    <= cfg_d_d;
      end
   end

   assign CFG_WE = cfg_we_q;
   assign CFG_D  = cfg_d_q;
   assign RDATA  = rdata_q;
   assign RVALID = rvalid_q;
   assign ERR    = err_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: behavioural 128-bit chain plus an
// arithmetic model of what the chain and readback stream must contain.
module tb_cfg_loader;

   localparam int CW = 128;
   localparam int NB = CW / 8;

   logic       CLK = 1'b0, RST = 1'b1, START = 1'b0, ABORT = 1'b0, DIN_VALID = 1'b0;
   logic [7:0] DIN = '0;
   logic       CFG_Q;
   logic       DIN_READY, CFG_WE, CFG_D, RVALID, BUSY, DONE, ERR;
   logic [7:0] RDATA;

   logic [CW-1:0] chain = '0;
   logic [CW-1:0] exp_chain = '0;
   int checks = 0, failures = 0;
   int cyc = 0, we_cnt = 0, done_cnt = 0, done_cyc = 0, cfg_d_bad = 0;
   int start_cyc = 0, hs_timeouts = 0, gap_bad = 0;
   logic [7:0] rb_q[$];

   cfg_loader #(.CFG_WIDTH(CW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
      .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
      .CFG_WE(CFG_WE), .CFG_D(CFG_D), .CFG_Q(CFG_Q),
      .RDATA(RDATA), .RVALID(RVALID), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // External chain: shifts toward bit 0, serial out is bit 0.
   assign CFG_Q = chain[0];
   always @(posedge CLK) if (CFG_WE === 1'b1) chain <= {CFG_D, chain[CW-1:1]};

   always @(posedge CLK) begin
      #1;
      cyc++;
      if (CFG_WE === 1'b1) we_cnt++;
      if (CFG_WE === 1'b0 && CFG_D !== 1'b0) cfg_d_bad++;
      if (RVALID === 1'b1) rb_q.push_back(RDATA);
      if (DONE === 1'b1) begin done_cnt++; done_cyc = cyc; end
   end

   function automatic logic [CW-1:0] pack(input logic [7:0] b [NB]);
      logic [CW-1:0] d;
      d = '0;
      for (int k = 0; k < NB; k++) d[8*k +: 8] = b[k];
      return d;
   endfunction

   // Chain contents after the first nbits of stream d have been shifted in.
   function automatic logic [CW-1:0] after_shift(input logic [CW-1:0] old,
                                                 input logic [CW-1:0] d, input int nbits);
      logic [CW-1:0] mask;
      if (nbits == 0) return old;
      mask = (nbits >= CW) ? '1 : ((CW'(1) << nbits) - CW'(1));
      return (old >> nbits) | ((d & mask) << (CW - nbits));
   endfunction

   task automatic rand_bytes(output logic [7:0] b [NB]);
      for (int k = 0; k < NB; k++) b[k] = 8'($urandom);
   endtask

   task automatic run_load(input logic [7:0] b [NB], input int gap_idx, input int gap_len,
                           input int stop_byte, input int stop_cyc, input bit use_rst,
                           input int start_byte);
      int n;
      START = 1'b1; start_cyc = cyc;
      @(negedge CLK); START = 1'b0;
      for (int i = 0; i < NB; i++) begin
         n = 0;
         while (DIN_READY !== 1'b1 && n < 40) begin
            DIN_VALID = 1'($urandom_range(0, 1)); DIN = 8'($urandom);
            @(negedge CLK); START = 1'b0; n++;
         end
         DIN_VALID = 1'b0;
         if (DIN_READY !== 1'b1) begin hs_timeouts++; return; end
         if (i == gap_idx) repeat (gap_len) begin
            @(negedge CLK);
            if (CFG_WE !== 1'b0 || BUSY !== 1'b1) gap_bad++;
         end
         DIN = b[i]; DIN_VALID = 1'b1;
         @(negedge CLK); DIN_VALID = 1'b0;
         if (i == start_byte) START = 1'b1;
         if (i == stop_byte) begin
            repeat (stop_cyc - 1) @(negedge CLK);
            START = 1'b0;
            if (use_rst) RST = 1'b1; else ABORT = 1'b1;
            @(negedge CLK); RST = 1'b0; ABORT = 1'b0;
            return;
         end
      end
   endtask

   task automatic wait_done(input int bd);
      int n = 0;
      while (done_cnt == bd && n < 400) begin @(negedge CLK); n++; end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      checks++; if ({BUSY, DONE, ERR, DIN_READY, CFG_WE, CFG_D, RVALID} !== 7'b0) begin failures++; $display("FAIL reset_flags: got %b want 0000000", {BUSY, DONE, ERR, DIN_READY, CFG_WE, CFG_D, RVALID}); end
      checks++; if (RDATA !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h want 00", RDATA); end
      RST = 1'b0;
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0 || DIN_READY !== 1'b0) begin failures++; $display("FAIL idle_after_reset: busy=%b ready=%b want 0 0", BUSY, DIN_READY); end
   endtask

   task automatic test_full_load();
      logic [7:0] b [NB];
      logic [CW-1:0] old, want;
      int bw, bd, br, bad;
      for (int k = 0; k < NB; k++) b[k] = 8'(k);
      want = '0;
      for (int k = 0; k < NB; k++) want[8*k +: 8] = 8'(k);
      old = exp_chain; bw = we_cnt; bd = done_cnt; br = rb_q.size(); hs_timeouts = 0;
      run_load(b, -1, 0, -1, 0, 1'b0, -1);
      wait_done(bd);
      exp_chain = after_shift(old, pack(b), CW);
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL full_after_done: busy=%b done=%b want 0 0", BUSY, DONE); end
      repeat (3) @(negedge CLK);
      checks++; if (hs_timeouts !== 0) begin failures++; $display("FAIL full_handshake: timeouts=%0d want 0", hs_timeouts); end
      checks++; if (chain !== want) begin failures++; $display("FAIL full_chain: got %h want %h", chain, want); end
      checks++; if (we_cnt - bw !== CW) begin failures++; $display("FAIL full_we_cycles: got %0d want %0d", we_cnt - bw, CW); end
      checks++; if (done_cnt - bd !== 1) begin failures++; $display("FAIL full_done_count: got %0d want 1", done_cnt - bd); end
      checks++; if (done_cyc - start_cyc !== 145) begin failures++; $display("FAIL full_latency: got %0d want 145", done_cyc - start_cyc); end
      checks++; if (rb_q.size() - br !== NB) begin failures++; $display("FAIL full_rvalid_count: got %0d want %0d", rb_q.size() - br, NB); end
      bad = 0;
      for (int k = 0; k < NB; k++) if (rb_q[br + k] !== old[8*k +: 8]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL full_readback: bad_bytes=%0d want 0", bad); end
   endtask

   task automatic test_readback();
      logic [7:0] b [NB];
      logic [CW-1:0] old;
      int bd, br, bad;
      for (int k = 0; k < NB; k++) b[k] = 8'hA5;
      old = exp_chain; bd = done_cnt; br = rb_q.size(); hs_timeouts = 0;
      run_load(b, -1, 0, -1, 0, 1'b0, -1);
      wait_done(bd);
      exp_chain = after_shift(old, pack(b), CW);
      repeat (3) @(negedge CLK);
      bad = 0;
      for (int k = 0; k < NB; k++) if (rb_q[br + k] !== 8'(k)) bad++;
      checks++; if (bad !== 0 || rb_q.size() - br !== NB) begin failures++; $display("FAIL rb_sequence: bad=%0d count=%0d want 0 %0d", bad, rb_q.size() - br, NB); end
      checks++; if (chain !== {NB{8'hA5}}) begin failures++; $display("FAIL rb_chain: got %h want all a5", chain); end
   endtask

   task automatic test_stall();
      logic [7:0] b [NB];
      logic [CW-1:0] old;
      int bw, bd, br;
      rand_bytes(b);
      old = exp_chain; bw = we_cnt; bd = done_cnt; br = rb_q.size(); hs_timeouts = 0; gap_bad = 0;
      run_load(b, 4, 5, -1, 0, 1'b0, -1);
      wait_done(bd);
      exp_chain = after_shift(old, pack(b), CW);
      repeat (3) @(negedge CLK);
      checks++; if (gap_bad !== 0) begin failures++; $display("FAIL stall_gap: bad_cycles=%0d want 0", gap_bad); end
      checks++; if (chain !== exp_chain) begin failures++; $display("FAIL stall_chain: got %h want %h", chain, exp_chain); end
      checks++; if (done_cyc - start_cyc !== 150) begin failures++; $display("FAIL stall_latency: got %0d want 150", done_cyc - start_cyc); end
      checks++; if (we_cnt - bw !== CW) begin failures++; $display("FAIL stall_we_cycles: got %0d want %0d", we_cnt - bw, CW); end
   endtask

   task automatic test_mid_start();
      logic [7:0] b [NB];
      logic [CW-1:0] old;
      int bd, br, bad;
      rand_bytes(b);
      old = exp_chain; bd = done_cnt; br = rb_q.size(); hs_timeouts = 0;
      run_load(b, -1, 0, -1, 0, 1'b0, 5);
      wait_done(bd);
      exp_chain = after_shift(old, pack(b), CW);
      repeat (3) @(negedge CLK);
      bad = 0;
      for (int k = 0; k < NB; k++) if (rb_q[br + k] !== old[8*k +: 8]) bad++;
      checks++; if (chain !== exp_chain) begin failures++; $display("FAIL midstart_chain: got %h want %h", chain, exp_chain); end
      checks++; if (done_cnt - bd !== 1 || done_cyc - start_cyc !== 145) begin failures++; $display("FAIL midstart_done: count=%0d lat=%0d want 1 145", done_cnt - bd, done_cyc - start_cyc); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL midstart_readback: bad_bytes=%0d want 0", bad); end
   endtask

   task automatic test_abort();
      logic [7:0] b [NB];
      logic [CW-1:0] old;
      int bw, bd, br;
      rand_bytes(b);
      old = exp_chain; bw = we_cnt; bd = done_cnt; br = rb_q.size();
      run_load(b, -1, 0, 2, 4, 1'b0, -1);
      checks++; if ({CFG_WE, ERR, BUSY} !== 3'b010) begin failures++; $display("FAIL abort_flags: we_err_busy=%b want 010", {CFG_WE, ERR, BUSY}); end
      repeat (4) @(negedge CLK);
      exp_chain = after_shift(old, pack(b), 20);
      checks++; if (we_cnt - bw !== 20) begin failures++; $display("FAIL abort_we_cycles: got %0d want 20", we_cnt - bw); end
      checks++; if (done_cnt !== bd) begin failures++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - bd); end
      checks++; if (rb_q.size() - br !== 2) begin failures++; $display("FAIL abort_rvalid_count: got %0d want 2", rb_q.size() - br); end
      checks++; if (chain !== exp_chain) begin failures++; $display("FAIL abort_chain: got %h want %h", chain, exp_chain); end
      checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL abort_err_sticky: got %b want 1", ERR); end
   endtask

   task automatic test_abort_handshake();
      logic [CW-1:0] old;
      int bw, bd, br;
      old = exp_chain; bw = we_cnt; bd = done_cnt; br = rb_q.size();
      START = 1'b1;
      @(negedge CLK); START = 1'b0;
      checks++; if ({ERR, BUSY, DIN_READY} !== 3'b011) begin failures++; $display("FAIL start_clears_err: err_busy_ready=%b want 011", {ERR, BUSY, DIN_READY}); end
      DIN = 8'($urandom); DIN_VALID = 1'b1; ABORT = 1'b1;
      @(negedge CLK); DIN_VALID = 1'b0; ABORT = 1'b0;
      checks++; if ({CFG_WE, ERR, BUSY} !== 3'b010) begin failures++; $display("FAIL abort_hs_flags: we_err_busy=%b want 010", {CFG_WE, ERR, BUSY}); end
      repeat (10) @(negedge CLK);
      checks++; if (we_cnt !== bw || done_cnt !== bd || rb_q.size() !== br) begin failures++; $display("FAIL abort_hs_dropped: we=%0d done=%0d rv=%0d want 0 0 0", we_cnt - bw, done_cnt - bd, rb_q.size() - br); end
      checks++; if (chain !== old) begin failures++; $display("FAIL abort_hs_chain: got %h want %h", chain, old); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b [NB];
      logic [CW-1:0] old;
      int bw, bd;
      rand_bytes(b);
      old = exp_chain; bw = we_cnt; bd = done_cnt;
      run_load(b, -1, 0, 2, 3, 1'b1, -1);
      checks++; if ({BUSY, DONE, ERR, DIN_READY, CFG_WE, CFG_D, RVALID} !== 7'b0 || RDATA !== 8'h00) begin failures++; $display("FAIL rstmid_outputs: flags=%b rdata=%h want 0000000 00", {BUSY, DONE, ERR, DIN_READY, CFG_WE, CFG_D, RVALID}, RDATA); end
      repeat (10) @(negedge CLK);
      exp_chain = after_shift(old, pack(b), 19);
      checks++; if (done_cnt !== bd) begin failures++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - bd); end
      checks++; if (we_cnt - bw !== 19 || chain !== exp_chain) begin failures++; $display("FAIL rstmid_chain: we=%0d chain=%h want 19 %h", we_cnt - bw, chain, exp_chain); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rstmid_idle: busy=%b want 0", BUSY); end
   endtask

   task automatic test_random_loads();
      logic [7:0] b [NB];
      logic [CW-1:0] old;
      int bd, br, bad, gi, gl;
      for (int it = 0; it < 3; it++) begin
         rand_bytes(b);
         gi = $urandom_range(1, NB - 1); gl = $urandom_range(1, 6);
         old = exp_chain; bd = done_cnt; br = rb_q.size(); hs_timeouts = 0;
         run_load(b, gi, gl, -1, 0, 1'b0, -1);
         wait_done(bd);
         exp_chain = after_shift(old, pack(b), CW);
         repeat (3) @(negedge CLK);
         bad = 0;
         for (int k = 0; k < NB; k++) if (rb_q[br + k] !== old[8*k +: 8]) bad++;
         checks++; if (chain !== exp_chain) begin failures++; $display("FAIL rand%0d_chain: got %h want %h", it, chain, exp_chain); end
         checks++; if (bad !== 0 || rb_q.size() - br !== NB) begin failures++; $display("FAIL rand%0d_readback: bad=%0d count=%0d want 0 %0d", it, bad, rb_q.size() - br, NB); end
         checks++; if (done_cyc - start_cyc !== 145 + gl) begin failures++; $display("FAIL rand%0d_latency: got %0d want %0d", it, done_cyc - start_cyc, 145 + gl); end
      end
      checks++; if (cfg_d_bad !== 0) begin failures++; $display("FAIL cfg_d_idle_zero: bad_cycles=%0d want 0", cfg_d_bad); end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_readback();
      test_stall();
      test_mid_start();
      test_abort();
      test_abort_handshake();
      test_reset_mid();
      test_random_loads();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Byte-parallel front end for the serial configuration chain; sits directly upstream of the configuration shift register.
- Accepts configuration bytes over a valid/ready interface and serialises them LSB-first onto the chain's write-enable/data pins.
- Simultaneously captures the chain's serial output, so the previous configuration is read back byte-by-byte during every load.

Parameters:
- CFG_WIDTH, 128, total chain length in bits; must be a multiple of 8 (elaboration error otherwise).
- NBYTES, CFG_WIDTH/8, bytes per full load (derived, not overridable).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- START  in  1  begin a full load (pulse)
- ABORT  in  1  cancel an in-progress load (pulse)
- DIN  in  8  configuration byte; byte 0 carries chain bits [7:0]
- DIN_VALID  in  1  DIN valid
- DIN_READY  out  1  byte accepted when DIN_VALID & DIN_READY
- CFG_WE  out  1  to chain write enable
- CFG_D  out  1  to chain serial data in
- CFG_Q  in  1  from chain serial data out
- RDATA  out  8  readback byte of previous configuration
- RVALID  out  1  one-cycle strobe; RDATA valid; no backpressure
- BUSY  out  1  load in progress
- DONE  out  1  one-cycle pulse when all CFG_WIDTH bits are shifted
- ERR  out  1  sticky; last load was aborted

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST).
- While RST is high, at the next edge all outputs go to 0 and the state goes to IDLE. This applies mid-load: the chain is left partially shifted, and no DONE or ERR is produced.
- States: IDLE, WAIT_BYTE, SHIFT, FINISH.
- IDLE:
  - BUSY=0 and DIN_READY=0.
  - START -> WAIT_BYTE; clears ERR; byte counter=0. BUSY rises on the cycle after START.
- WAIT_BYTE:
  - BUSY=1, DIN_READY=1, CFG_WE=0.
  - On handshake: load DIN into an 8-bit data shifter, bit counter=0, go to SHIFT. DIN_READY drops in the next cycle.
- SHIFT:
  - CFG_WE=1 and CFG_D=shifter[0] for exactly 8 consecutive cycles; shifter shifts right each cycle.
  - Each SHIFT cycle, CFG_Q is captured MSB-side into an 8-bit readback shifter (rsh <= {CFG_Q, rsh[7:1]}). CFG_Q is the chain bit being shifted out in that same cycle.
  - After the 8th cycle:
    - RDATA <= completed readback byte, RVALID=1 for one cycle.
    - Byte counter increments.
    - If counter reaches NBYTES -> FINISH, else -> WAIT_BYTE.
- FINISH: DONE=1 for one cycle, BUSY=0 from the next cycle, -> IDLE.
- CFG_WE and CFG_D are registered outputs. CFG_D=0 whenever CFG_WE=0.
- Ordering: after a full load, chain bit k equals bit (k mod 8) of byte k/8. The first bit driven ends at chain bit 0.
- Readback: the k-th RVALID returns bits [8k+7:8k] of the chain contents present before START.
- Throughput: 9 cycles per byte minimum. A full load at 128 bits is 144 cycles plus input stalls.
- START while BUSY: ignored.
- ABORT:
  - In WAIT_BYTE or SHIFT -> IDLE next cycle; CFG_WE=0 immediately, ERR=1, no DONE.
  - A partial readback byte is discarded.
  - ABORT in IDLE or FINISH is ignored.
  - ABORT and a DIN handshake in the same cycle: ABORT wins and the byte is dropped.
- DIN_VALID outside WAIT_BYTE has no effect.
- While CFG_WE=1 the chain holds its decoded outputs at 0. Downstream logic must treat BUSY=1 as "configuration invalid".

Decomposition:
- Shared package: CFG_WIDTH default (128 = 5+5+5+9+96+4+4); state enumeration IDLE/WAIT_BYTE/SHIFT/FINISH; byte width constant 8.
- One natural sub-module: cfg_bit_serdes. It holds the 8-bit TX shifter, the 8-bit RX shifter and the 3-bit bit counter, takes a load/shift control from the FSM, and reports byte_done.
- The FSM and byte counter stay in cfg_loader.

Test Plan:
- Reset, then full load of bytes 0x00..0x0F into a behavioural 128-bit chain model:
  - chain = 0x0F0E...0100 (byte k at bits [8k+7:8k]);
  - DONE pulses once 1 cycle after the last shift;
  - exactly 128 CFG_WE cycles;
  - 16 RVALID strobes, all RDATA=0x00.
- Second load with bytes all 0xA5:
  - readback RDATA sequence = 0x00,0x01,...,0x0F;
  - final chain = 0xA5 repeated.
- DIN_VALID held low for 5 cycles between bytes 3 and 4:
  - CFG_WE stays 0 during the gap, BUSY stays 1;
  - final chain matches the no-stall case.
- ABORT in the 4th SHIFT cycle of byte 2:
  - CFG_WE=0 next cycle, ERR=1, no DONE, BUSY=0;
  - exactly 20 CFG_WE cycles in total;
  - a following START clears ERR.
- START asserted again mid-load: no effect, and the load completes normally. RST asserted mid-load: all outputs 0 at the next edge, state IDLE, no DONE.
- ABORT coincident with a DIN handshake in WAIT_BYTE: byte dropped, zero CFG_WE cycles for it, ERR=1.
